control_sequencer: RTL
======================

# control_sequencer

Hardwired control unit for the 32-bit bus CPU. It sits directly upstream of the datapath and drives every datapath strobe: register/bus-select enables, the IR-field select lines, memory Read/Write and the 5-bit ALU `operation`. It reads the instruction opcode back from the IR and sequences fetch and execute as a Moore FSM. Memory accesses are stretched by a ready handshake.

## Interface
- Parameters:
  - `ADD_OP`, default 5'b00011, ALU code used for address and immediate addition.
- Ports:
  - `clock` input 1: rising-edge clock.
  - `clear` input 1: asynchronous, active-high reset.
  - `opcode` input 5: IR[31:27] from the datapath IR.
  - `mem_ready` input 1: memory finished the current Read/Write this cycle.
  - `PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout` output 1 each: bus source selects.
  - `MAR_enable, MDR_enable, IR_enable, Y_enable, PC_enable, Z_low_enable, Z_high_enable, HI_enable, LO_enable` output 1 each: register load enables.
  - `IncPC, Read, Write` output 1 each: PC increment and memory strobes.
  - `GRA, GRB, GRC, Rin, Rout, BAout` output 1 each: IR register-field selects.
  - `operation` output 5: ALU opcode.
  - `run` output 1: high while executing, low in HALT or in reset.
  - `illegal` output 1: one-cycle pulse on an unsupported opcode.

## Operation
- State register is updated on the rising edge of `clock`. Outputs decode combinationally from the state and `opcode` only (Moore). Unlisted outputs are 0 in every state. `operation` is 0 unless listed.
- The load enables `Z_low_enable` and `Z_high_enable` are always asserted together, written "Zin" below.
- Fetch sequence:
  - T0: PCout, MAR_enable, IncPC.
  - T1: Read, MDR_enable. Hold T1 while `mem_ready`=0.
  - T2: MDRout, IR_enable.
  - T3: first execute state, dispatched on `opcode`.
- Reg-reg ALU (opcodes 00011–01011: add, sub, and, or, ror, rol, shr, shra, shl):
  - T3: GRB, Rout, Y_enable.
  - T4: GRC, Rout, operation=opcode, Zin.
  - T5: ZLowout, GRA, Rin.
  - Then T0.
- Immediate ops addi/andi/ori (01100/01101/01110), which map to ALU 00011/00101/00110:
  - T3: GRB, Rout, Y_enable.
  - T4: Cout, mapped operation, Zin.
  - T5: ZLowout, GRA, Rin.
- neg/not (10001/10010):
  - T3: GRB, Rout, operation=opcode, Zin.
  - T4: ZLowout, GRA, Rin.
- div/mul (01111/10000):
  - T3: GRA, Rout, Y_enable.
  - T4: GRB, Rout, operation=opcode, Zin.
  - T5: ZLowout, LO_enable.
  - T6: ZHighout, HI_enable.
- ldi (00001):
  - T3: GRB, BAout, Y_enable.
  - T4: Cout, operation=ADD_OP, Zin.
  - T5: ZLowout, GRA, Rin.
- ld (00000):
  - T3–T4: as ldi.
  - T5: ZLowout, MAR_enable.
  - T6: Read, MDR_enable. Hold T6 while `mem_ready`=0.
  - T7: MDRout, GRA, Rin.
- st (00010):
  - T3–T5: as ld.
  - T6: GRA, Rout, MDR_enable (Read=0).
  - T7: Write. Hold T7 while `mem_ready`=0.
- mfhi/mflo (11000/11001): T3: HIout or LOout, GRA, Rin.
- nop (11010): T3 asserts nothing, then T0.
- halt (11011): enter HALT. All outputs are 0 and `run`=0. HALT is left only via `clear`.
- Any other opcode: T3 asserts nothing and pulses `illegal` for 1 cycle, then T0. It is treated as a nop.

## Timing
- `clear`=1 asynchronously sets state to RESET. In RESET all outputs, including `run` and `illegal`, are 0.
- The first rising edge with `clear`=0 moves RESET to T0. `run`=1 from T0 onward.
- Cycle counts with `mem_ready` already high (the Read in T1 completes in 1 cycle):
  - fetch: 3 cycles.
  - reg-reg, immediate, ldi: 6 cycles.
  - neg/not: 5 cycles.
  - mul/div: 7 cycles.
  - ld/st: 8 cycles.
  - mfhi/mflo, nop: 4 cycles.
- Each extra cycle with `mem_ready`=0 in T1, T6 (ld) or T7 (st) adds one cycle. Read/Write and MDR_enable stay asserted for the whole wait.
- `mem_ready` is ignored in every other state.
- `opcode` is sampled only in T3, never in T0–T2.
- `clear` asserted mid-instruction, including during a memory wait, aborts immediately: all strobes drop in the same cycle. No partial write-back completes after `clear` rises.

## Test plan
- Reset: hold `clear`=1 for 3 cycles → every output 0. Release → next cycle shows PCout=MAR_enable=IncPC=1 and `run`=1.
- add (00011), `mem_ready` tied 1 → states T0..T5 over 6 cycles. `operation`=00011 with Zin only in T4; GRA&Rin only in T5; return to T0.
- ld (00000), `mem_ready` low 2 extra cycles in both T1 and T6 → Read=MDR_enable=1 for 3 cycles each time. Total 12 cycles; GRA&Rin with MDRout in the last cycle.
- st (00010), `mem_ready` low 1 cycle in T7 → Write=1 for 2 cycles, Read never 1 after T1. Total 9 cycles.
- mul (10000) then halt (11011) → LO_enable in cycle 6, HI_enable in cycle 7. After halt fetch, `run`=0 and outputs stay 0 for 20+ cycles.
- Opcode 11111 → `illegal`=1 exactly in T3, then T0. Separately, `clear` pulsed during ld T6 → outputs 0 at once, fetch resumes at T0 after release.

Source files
------------

// File: rtl/control_sequencer_if.sv
// control_sequencer_if
// Bundles the strobes between the hardwired control unit and the 32-bit datapath.
//   master (control unit): drives all strobes, run, illegal; samples opcode, mem_ready.
//   slave  (datapath)    : the mirror image.
interface control_sequencer_if;
    // Datapath -> control
    logic [4:0] opcode;
    logic       mem_ready;
    // Bus source selects
    logic       PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout;
    // Register load enables
    logic       MAR_enable, MDR_enable, IR_enable, Y_enable, PC_enable;
    logic       Z_low_enable, Z_high_enable, HI_enable, LO_enable;
    // PC increment and memory strobes
    logic       IncPC, Read, Write;
    // IR register-field selects
    logic       GRA, GRB, GRC, Rin, Rout, BAout;
    // ALU opcode and status
    logic [4:0] operation;
    logic       run;
    logic       illegal;

    modport master (
        input  opcode, mem_ready,
        output PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout,
        output MAR_enable, MDR_enable, IR_enable, Y_enable, PC_enable,
        output Z_low_enable, Z_high_enable, HI_enable, LO_enable,
        output IncPC, Read, Write,
        output GRA, GRB, GRC, Rin, Rout, BAout,
        output operation, run, illegal
    );

    modport slave (
        output opcode, mem_ready,
        input  PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout,
        input  MAR_enable, MDR_enable, IR_enable, Y_enable, PC_enable,
        input  Z_low_enable, Z_high_enable, HI_enable, LO_enable,
        input  IncPC, Read, Write,
        input  GRA, GRB, GRC, Rin, Rout, BAout,
        input  operation, run, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
// Hardwired Moore-FSM control unit for the 32-bit bus CPU. Sequences fetch (T0-T2) and
// execute (T3-T7), stretching memory accesses until mem_ready.
//   clock : rising-edge clock
//   clear : asynchronous active-high reset, aborts any instruction immediately
//   bus   : control_sequencer_if master modport (all datapath strobes, opcode, mem_ready)
module control_sequencer #(
    parameter logic [4:0] ADD_OP = 5'b00011
) (
    input  logic                clock,
    input  logic                clear,
    control_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        StReset, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
    } state_e;

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpLdi  = 5'b00001;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAddi = 5'b01100;
    localparam logic [4:0] OpAndi = 5'b01101;
    localparam logic [4:0] OpMfhi = 5'b11000;
    localparam logic [4:0] OpMflo = 5'b11001;
    localparam logic [4:0] OpNop  = 5'b11010;
    localparam logic [4:0] OpHalt = 5'b11011;

    state_e     r_state;
    state_e     w_next;
    logic [4:0] r_op;   // opcode captured in T3; IR may not be trusted to hold it later
    logic [4:0] w_op;
    logic       w_zin;
    logic [4:0] w_imm_alu;

    function automatic logic is_alu(input logic [4:0] op);
        return (op >= 5'b00011) && (op <= 5'b01011);
    endfunction

    function automatic logic is_imm(input logic [4:0] op);
        return (op >= 5'b01100) && (op <= 5'b01110);
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == 5'b01111) || (op == 5'b10000);
    endfunction

    function automatic logic is_neg(input logic [4:0] op);
        return (op == 5'b10001) || (op == 5'b10010);
    endfunction

    // Opcode in effect: live during T3 (the dispatch cycle), latched copy afterwards.
    assign w_op = (r_state == StT3) ? bus.opcode : r_op;

    always_comb begin
        w_imm_alu = 5'b00110;
        if (w_op == OpAddi) begin
            w_imm_alu = 5'b00011;
        end else if (w_op == OpAndi) begin
            w_imm_alu = 5'b00101;
        end
    end

    // State register
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= StReset;
            r_op    <= 5'b00000;
        end else begin
            r_state <= w_next;
            if (r_state == StT3) begin
                r_op <= bus.opcode;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StReset: w_next = StT0;
            StT0:    w_next = StT1;
            StT1:    w_next = bus.mem_ready ? StT2 : StT1;
            StT2:    w_next = StT3;
            StT3: begin
                if (is_alu(w_op) || is_imm(w_op) || is_muldiv(w_op) || is_neg(w_op) ||
                    (w_op == OpLdi) || (w_op == OpLd) || (w_op == OpSt)) begin
                    w_next = StT4;
                end else if (w_op == OpHalt) begin
                    w_next = StHalt;
                end else begin
                    w_next = StT0;
                end
            end
            StT4:    w_next = is_neg(w_op) ? StT0 : StT5;
            StT5: begin
                if (is_muldiv(w_op) || (w_op == OpLd) || (w_op == OpSt)) begin
                    w_next = StT6;
                end else begin
                    w_next = StT0;
                end
            end
            StT6: begin
                if (w_op == OpLd) begin
                    w_next = bus.mem_ready ? StT7 : StT6;
                end else if (w_op == OpSt) begin
                    w_next = StT7;
                end else begin
                    w_next = StT0;
                end
            end
            StT7: begin
                if (w_op == OpSt) begin
                    w_next = bus.mem_ready ? StT0 : StT7;
                end else begin
                    w_next = StT0;
                end
            end
            StHalt:  w_next = StHalt;
            default: w_next = StReset;
        endcase
    end

    assign bus.Z_low_enable  = w_zin;
    assign bus.Z_high_enable = w_zin;

    // Output decode
    always_comb begin
        bus.PCout      = 1'b0;
        bus.ZLowout    = 1'b0;
        bus.ZHighout   = 1'b0;
        bus.MDRout     = 1'b0;
        bus.HIout      = 1'b0;
        bus.LOout      = 1'b0;
        bus.Cout       = 1'b0;
        bus.InPortout  = 1'b0;
        bus.MAR_enable = 1'b0;
        bus.MDR_enable = 1'b0;
        bus.IR_enable  = 1'b0;
        bus.Y_enable   = 1'b0;
        bus.PC_enable  = 1'b0;
        bus.HI_enable  = 1'b0;
        bus.LO_enable  = 1'b0;
        bus.IncPC      = 1'b0;
        bus.Read       = 1'b0;
        bus.Write      = 1'b0;
        bus.GRA        = 1'b0;
        bus.GRB        = 1'b0;
        bus.GRC        = 1'b0;
        bus.Rin        = 1'b0;
        bus.Rout       = 1'b0;
        bus.BAout      = 1'b0;
        bus.operation  = 5'b00000;
        bus.illegal    = 1'b0;
        w_zin          = 1'b0;
        bus.run        = (r_state != StReset) && (r_state != StHalt);
        unique case (r_state)
            StT0: begin
                bus.PCout      = 1'b1;
                bus.MAR_enable = 1'b1;
                bus.IncPC      = 1'b1;
            end
            StT1: begin
                bus.Read       = 1'b1;
                bus.MDR_enable = 1'b1;
            end
            StT2: begin
                bus.MDRout    = 1'b1;
                bus.IR_enable = 1'b1;
            end
            StT3: begin
                if (is_alu(w_op) || is_imm(w_op)) begin
                    bus.GRB      = 1'b1;
                    bus.Rout     = 1'b1;
                    bus.Y_enable = 1'b1;
                end else if (is_neg(w_op)) begin
                    bus.GRB       = 1'b1;
                    bus.Rout      = 1'b1;
                    bus.operation = w_op;
                    w_zin         = 1'b1;
                end else if (is_muldiv(w_op)) begin
                    bus.GRA      = 1'b1;
                    bus.Rout     = 1'b1;
                    bus.Y_enable = 1'b1;
                end else if ((w_op == OpLdi) || (w_op == OpLd) || (w_op == OpSt)) begin
                    bus.GRB      = 1'b1;
                    bus.BAout    = 1'b1;
                    bus.Y_enable = 1'b1;
                end else if ((w_op == OpMfhi) || (w_op == OpMflo)) begin
                    bus.HIout = (w_op == OpMfhi);
                    bus.LOout = (w_op == OpMflo);
                    bus.GRA   = 1'b1;
                    bus.Rin   = 1'b1;
                end else if ((w_op != OpNop) && (w_op != OpHalt)) begin
                    bus.illegal = 1'b1;
                end
            end
            StT4: begin
                if (is_alu(w_op)) begin
                    bus.GRC       = 1'b1;
                    bus.Rout      = 1'b1;
                    bus.operation = w_op;
                    w_zin         = 1'b1;
                end else if (is_imm(w_op)) begin
                    bus.Cout      = 1'b1;
                    bus.operation = w_imm_alu;
                    w_zin         = 1'b1;
                end else if (is_neg(w_op)) begin
                    bus.ZLowout = 1'b1;
                    bus.GRA     = 1'b1;
                    bus.Rin     = 1'b1;
                end else if (is_muldiv(w_op)) begin
                    bus.GRB       = 1'b1;
                    bus.Rout      = 1'b1;
                    bus.operation = w_op;
                    w_zin         = 1'b1;
                end else begin
                    // ldi / ld / st: effective address = base + C
                    bus.Cout      = 1'b1;
                    bus.operation = ADD_OP;
                    w_zin         = 1'b1;
                end
            end
            StT5: begin
                bus.ZLowout = 1'b1;
                if (is_muldiv(w_op)) begin
                    bus.LO_enable = 1'b1;
                end else if ((w_op == OpLd) || (w_op == OpSt)) begin
                    bus.MAR_enable = 1'b1;
                end else begin
                    bus.GRA = 1'b1;
                    bus.Rin = 1'b1;
                end
            end
            StT6: begin
                if (is_muldiv(w_op)) begin
                    bus.ZHighout  = 1'b1;
                    bus.HI_enable = 1'b1;
                end else if (w_op == OpLd) begin
                    bus.Read       = 1'b1;
                    bus.MDR_enable = 1'b1;
                end else begin
                    bus.GRA        = 1'b1;
                    bus.Rout       = 1'b1;
                    bus.MDR_enable = 1'b1;
                end
            end
            StT7: begin
                if (w_op == OpLd) begin
                    bus.MDRout = 1'b1;
                    bus.GRA    = 1'b1;
                    bus.Rin    = 1'b1;
                end else begin
                    bus.Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
